bank_pkt_arbiter: RTL and testbench

//  Round-robin arbiter that shares one network link between N_BANKS bank

---
 rtl/bank_pkg.sv | 14 +
 rtl/bank_pkt_arbiter_rr_pick.sv | 32 +++
 rtl/bank_pkt_arbiter.sv | 107 ++++++++++
 tb/tb_bank_pkt_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared types for the bank router -> network link arbiter.
package bank_pkg;

   localparam int NODE_ID_W  = 16;
   localparam int PATH_CNT_W = 48;
   localparam int N_BANKS    = 4;

   // One path-count packet: which node it describes and its running count.
   typedef struct packed {
      logic [NODE_ID_W-1:0]  node_id;
      logic [PATH_CNT_W-1:0] path_cnt;
   } pkt_t;

endpackage

// File: rtl/bank_pkt_arbiter_rr_pick.sv
// Combinational round-robin select: first request at or after ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan ptr, ptr+1, ... ; the first hit wins and later hits are ignored.
   always_comb begin
      logic [IW-1:0] i;
      logic          found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      i     = '0;
      for (int k = 0; k < N; k++) begin
         i = IW'((int'(ptr_i) + k) % N);
         if (!found && req_i[i]) begin
            found    = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = i;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/bank_pkt_arbiter.sv
// Round-robin arbiter sharing one registered link stage among the banks,
// with a forwarded-packet counter and a quiescence detector.
module bank_pkt_arbiter
   import bank_pkg::*;
#(
   parameter int N_BANKS      = bank_pkg::N_BANKS,
   parameter int QUIET_CYCLES = 8,
   parameter int CNT_W        = 32,
   localparam int SRC_W       = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
   localparam int IC_W        = $clog2(QUIET_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_BANKS-1:0]       req_valid,
   output logic [N_BANKS-1:0]       req_ready,
   input  pkt_t [N_BANKS-1:0]       req_pkt,
   input  logic [N_BANKS-1:0]       bank_idle,
   output logic                     out_valid,
   input  logic                     out_ready,
   output pkt_t                     out_pkt,
   output logic [SRC_W-1:0]         out_src,
   output logic [CNT_W-1:0]         pkt_count,
   output logic                     quiescent
);

   logic                 out_valid_q, out_valid_d;
   pkt_t                 out_pkt_q, out_pkt_d;
   logic [SRC_W-1:0]     out_src_q, out_src_d;
   logic [SRC_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IC_W-1:0]      idle_cnt_q, idle_cnt_d;
   logic                 quiet_q, quiet_d;

   logic [N_BANKS-1:0]   gnt;
   logic [SRC_W-1:0]     gnt_idx;
   logic                 gnt_any;
   logic                 can_load;
   logic                 xfer;
   logic                 idle;

   rr_pick #(.N(N_BANKS), .IW(SRC_W)) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // The output register can take a new packet when empty or being drained.
   assign can_load  = ~out_valid_q | out_ready;
   assign req_ready = rst_n ? (gnt & {N_BANKS{can_load}}) : '0;
   assign xfer      = rst_n & gnt_any & can_load;
   assign idle      = (&bank_idle) & ~(|req_valid) & ~out_valid_q;

   // Next state: load on transfer, empty on drain, saturating idle counter.
   always_comb begin
      out_valid_d = out_valid_q;
      out_pkt_d   = out_pkt_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      idle_cnt_d  = '0;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_pkt_d   = req_pkt[gnt_idx];
         out_src_d   = gnt_idx;
         ptr_d       = (gnt_idx == SRC_W'(N_BANKS - 1)) ? '0 : gnt_idx + SRC_W'(1);
         cnt_d       = cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (idle) begin
         idle_cnt_d = (idle_cnt_q == IC_W'(QUIET_CYCLES)) ? idle_cnt_q
                                                          : idle_cnt_q + IC_W'(1);
      end
      // Registered from the next count so it tracks idle_cnt exactly.
      quiet_d = (idle_cnt_d == IC_W'(QUIET_CYCLES));
   end

   // State registers; reset drops whatever sits in the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_pkt_q   <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         idle_cnt_q  <= '0;
         quiet_q     <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_pkt_q   <= out_pkt_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         quiet_q     <= quiet_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pkt   = out_pkt_q;
   assign out_src   = out_src_q;
   assign pkt_count = cnt_q;
   assign quiescent = quiet_q;

endmodule

// File: tb/tb_bank_pkt_arbiter.sv
// Bench for bank_pkt_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model and an in-order scoreboard.
module tb_bank_pkt_arbiter;
   import bank_pkg::*;

   localparam int NB = N_BANKS;
   localparam int QC = 8;
   localparam int CW = 32;
   localparam int SW = $clog2(NB);

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NB-1:0]    req_valid, req_ready, bank_idle;
   pkt_t [NB-1:0]    req_pkt;
   logic             out_valid, out_ready;
   pkt_t             out_pkt;
   logic [SW-1:0]    out_src;
   logic [CW-1:0]    pkt_count;
   logic             quiescent;

   always #5 clk = ~clk;

   bank_pkt_arbiter #(.N_BANKS(NB), .QUIET_CYCLES(QC), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_pkt   (req_pkt),
      .bank_idle (bank_idle),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pkt   (out_pkt),
      .out_src   (out_src),
      .pkt_count (pkt_count),
      .quiescent (quiescent)
   );

   typedef struct { pkt_t pkt; int src; } exp_t;
   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_ptr, m_idle;
   bit          m_ov, m_q;
   int unsigned m_cnt;
   pkt_t        held;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_ov = 0; m_cnt = 0; m_idle = 0; m_q = 0;
      sb.delete();
   endtask

   task automatic rand_pkts();
      for (int i = 0; i < NB; i++)
         req_pkt[i] = pkt_t'({16'($urandom), 16'($urandom), 32'($urandom)});
   endtask

   // Entered and left at a falling edge: drive, check, clock, update model.
   task automatic step(input logic [NB-1:0] v, input logic rdy, input logic [NB-1:0] idl);
      int            win;
      logic [NB-1:0] exp_rdy;
      bit            can_load, xfer, idle;
      req_valid = v; out_ready = rdy; bank_idle = idl;
      #1;
      chk("out_valid", out_valid, m_ov);
      if (m_ov && sb.size() > 0) begin
         chk("sb_pkt", out_pkt, sb[0].pkt);
         chk("sb_src", out_src, sb[0].src);
      end
      chk("pkt_count", pkt_count, m_cnt);
      chk("quiescent", quiescent, m_q);
      can_load = !m_ov || rdy;
      win = -1;
      for (int k = 0; k < NB; k++)
         if (win < 0 && v[(m_ptr + k) % NB]) win = (m_ptr + k) % NB;
      exp_rdy = '0;
      if (win >= 0 && can_load) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      xfer = (win >= 0) && can_load;
      idle = (&idl) && (v == '0) && !m_ov;
      if (m_ov && rdy) void'(sb.pop_front());
      if (xfer) sb.push_back('{req_pkt[win], win});
      @(posedge clk);
      if (xfer) begin
         m_ov = 1; m_ptr = (win + 1) % NB; m_cnt++;
      end else if (rdy) m_ov = 0;
      m_idle = idle ? ((m_idle < QC) ? m_idle + 1 : QC) : 0;
      m_q = (m_idle == QC);
      @(negedge clk);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_count"}, pkt_count, '0);
      chk({tag, "_quiet"}, quiescent, 1'b0);
      chk({tag, "_ready"}, req_ready, '0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; bank_idle = '0; req_pkt = '0;
      model_reset();
      @(negedge clk);
      do_reset("rst_init");

      // Single bank 2 packet, then mid-transfer reset while out_valid=1.
      rand_pkts();
      req_pkt[2] = '{node_id: 16'h0005, path_cnt: 48'd7};
      step(4'b0100, 1'b1, 4'b0000);
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_src",   out_src, 2);
      chk("t2_pkt",   out_pkt, 64'h0005_0000_0000_0007);
      chk("t2_count", pkt_count, 1);
      req_valid = '0;
      do_reset("rst_mid");

      // All banks valid with free link: grants 0,1,2,3,0 with no bubbles.
      for (int c = 0; c < 5; c++) begin
         rand_pkts();
         step(4'b1111, 1'b1, 4'b0000);
         chk("t3_src",   out_src, c % 4);
         chk("t3_valid", out_valid, 1'b1);
      end
      chk("t3_count", pkt_count, 5);

      // Back-pressure for 5 cycles, then release continues from bank 1.
      held = out_pkt;
      for (int c = 0; c < 5; c++) begin
         rand_pkts();
         step(4'b1111, 1'b0, 4'b0000);
         chk("t4_hold", out_pkt, held);
      end
      rand_pkts();
      step(4'b1111, 1'b1, 4'b0000);
      chk("t4_src", out_src, 1);

      // Dequeue and enqueue together: bank 1 alone, output stays valid.
      rand_pkts();
      held = req_pkt[1];
      step(4'b0010, 1'b1, 4'b0000);
      chk("t5_valid", out_valid, 1'b1);
      chk("t5_src",   out_src, 1);
      chk("t5_pkt",   out_pkt, held);

      // Quiescence after exactly 8 idle cycles; one request clears it.
      step(4'b0000, 1'b1, 4'b1111);
      for (int c = 1; c <= QC; c++) begin
         step(4'b0000, 1'b1, 4'b1111);
         chk("t6_quiet", quiescent, c == QC);
      end
      rand_pkts();
      step(4'b0001, 1'b1, 4'b1111);
      chk("t6_drop", quiescent, 1'b0);

      // Random traffic, back-pressure, idle stretches and occasional resets.
      for (int c = 0; c < 600; c++) begin
         logic [NB-1:0] v, idl;
         if ($urandom_range(0, 149) == 0) begin
            req_valid = '0;
            do_reset("rst_rand");
         end
         rand_pkts();
         v   = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
         idl = ($urandom_range(0, 4) == 0) ? NB'($urandom) : '1;
         step(v, $urandom_range(0, 3) != 0, idl);
      end
      step(4'b0000, 1'b1, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
